// File: rtl/startup_seq_pkg.sv
// rtl/startup_seq_pkg.sv - shared constants and parameter check for the startup sequencer
package startup_seq_pkg;

   localparam int PH_W  = 3;
   localparam int CNT_W = 8;

   localparam logic [PH_W-1:0] PH_IDLE = 3'd0;
   localparam logic [PH_W-1:0] PH_RUN  = 3'd5;

   function automatic bit params_ok(input int done_phase,
                                    input int goe_phase,
                                    input int gwd_phase,
                                    input int gsr_phase,
                                    input int sync_done,
                                    input int phase_cycles);
      bit ok;
      ok = 1'b1;
      if (done_phase < 1 || done_phase > 4)       ok = 1'b0;
      if (goe_phase < 1 || goe_phase > 4)         ok = 1'b0;
      if (gwd_phase < 1 || gwd_phase > 4)         ok = 1'b0;
      if (gsr_phase < 1 || gsr_phase > 4)         ok = 1'b0;
      if (sync_done < 0 || sync_done > 1)         ok = 1'b0;
      if (phase_cycles < 1 || phase_cycles > 255) ok = 1'b0;
      return ok;
   endfunction

endpackage

// File: rtl/startup_seq_gen_sync2.sv
// rtl/startup_seq_gen_sync2.sv - two-flop synchronizer, async active-high reset to 0
module sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/startup_seq_gen.sv
// rtl/startup_seq_gen.sv - wake-up sequencer releasing DONE, GOE, GWDIS and GSR by phase
module startup_seq_gen
   import startup_seq_pkg::*;
#(
   parameter int DONE_PHASE   = 1,
   parameter int GOE_PHASE    = 2,
   parameter int GWD_PHASE    = 3,
   parameter int GSR_PHASE    = 3,
   parameter int SYNC_DONE    = 0,
   parameter int PHASE_CYCLES = 1
) (
   input  logic            UCLK,
   input  logic            RST,
   input  logic            CFG_DONE,
   input  logic            DONE_IN,
   output logic            DONE_OUT,
   output logic            GOE,
   output logic            GWDIS,
   output logic            GSR,
   output logic [PH_W-1:0] PHASE,
   output logic            WAKEUP_DONE
);

   if (!params_ok(DONE_PHASE, GOE_PHASE, GWD_PHASE, GSR_PHASE, SYNC_DONE, PHASE_CYCLES)) begin : g_bad_params
      $error("startup_seq_gen: parameter out of range");
   end

   localparam logic [PH_W-1:0] ST_IDLE = PH_IDLE;
   localparam logic [PH_W-1:0] ST_P1   = 3'd1;
   localparam logic [PH_W-1:0] ST_P2   = 3'd2;
   localparam logic [PH_W-1:0] ST_P3   = 3'd3;
   localparam logic [PH_W-1:0] ST_P4   = 3'd4;
   localparam logic [PH_W-1:0] ST_RUN  = PH_RUN;

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PHASE_CYCLES - 1);
   localparam logic [PH_W-1:0]  DONE_PH  = PH_W'(DONE_PHASE);
   localparam logic [PH_W-1:0]  GOE_PH   = PH_W'(GOE_PHASE);
   localparam logic [PH_W-1:0]  GWD_PH   = PH_W'(GWD_PHASE);
   localparam logic [PH_W-1:0]  GSR_PH   = PH_W'(GSR_PHASE);

   logic             cfg_s;
   logic             done_s;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] next_cnt;
   logic [PH_W-1:0]  next_phase;
   logic             stall;

   sync2 u_sync_cfg (
      .clk (UCLK),
      .rst (RST),
      .d   (CFG_DONE),
      .q   (cfg_s)
   );

   sync2 u_sync_done (
      .clk (UCLK),
      .rst (RST),
      .d   (DONE_IN),
      .q   (done_s)
   );

   // The stall only blocks the phase exit; an unfinished countdown still runs.
   assign stall = (SYNC_DONE != 0) && (PHASE == DONE_PH) && !done_s;

   always_comb begin
      next_phase = PHASE;
      next_cnt   = cnt;
      case (PHASE)
         ST_IDLE: begin
            if (cfg_s) begin
               next_phase = ST_P1;
               next_cnt   = CNT_LOAD;
            end
         end
         ST_P1, ST_P2, ST_P3, ST_P4: begin
            if (cnt != '0) begin
               next_cnt = cnt - CNT_W'(1);
            end else if (!stall) begin
               next_phase = (PHASE == ST_P4) ? ST_RUN : PHASE + 3'd1;
               next_cnt   = CNT_LOAD;
            end
         end
         ST_RUN: begin
            next_phase = ST_RUN;
         end
         default: begin
            next_phase = ST_IDLE;
            next_cnt   = '0;
         end
      endcase
   end

   // Outputs decode next_phase so they move on the same edge as PHASE.
   always_ff @(posedge UCLK or posedge RST) begin
      if (RST) begin
         PHASE       <= ST_IDLE;
         cnt         <= '0;
         DONE_OUT    <= 1'b0;
         GOE         <= 1'b0;
         GWDIS       <= 1'b1;
         GSR         <= 1'b1;
         WAKEUP_DONE <= 1'b0;
      end else begin
         PHASE       <= next_phase;
         cnt         <= next_cnt;
         DONE_OUT    <= (next_phase >= DONE_PH);
         GOE         <= (next_phase >= GOE_PH);
         GWDIS       <= !(next_phase >= GWD_PH);
         GSR         <= !(next_phase >= GSR_PH);
         WAKEUP_DONE <= (next_phase == ST_RUN);
      end
   end

endmodule

// File: tb/tb_startup_seq_gen.sv
// tb/tb_startup_seq_gen.sv - directed self-checking bench for startup_seq_gen
module tb_startup_seq_gen;

   logic UCLK;
   logic RST;
   logic CFG_DONE;
   logic DONE_IN;

   logic [2:0] a_ph, b_ph, c_ph, d_ph;
   logic a_do, a_goe, a_gw, a_gsr, a_wk;
   logic b_do, b_goe, b_gw, b_gsr, b_wk;
   logic c_do, c_goe, c_gw, c_gsr, c_wk;
   logic d_do, d_goe, d_gw, d_gsr, d_wk;

   int total = 0;
   int bad   = 0;

   startup_seq_gen dut_a (
      .UCLK(UCLK), .RST(RST), .CFG_DONE(CFG_DONE), .DONE_IN(DONE_IN),
      .DONE_OUT(a_do), .GOE(a_goe), .GWDIS(a_gw), .GSR(a_gsr),
      .PHASE(a_ph), .WAKEUP_DONE(a_wk)
   );

   startup_seq_gen #(.PHASE_CYCLES(3)) dut_b (
      .UCLK(UCLK), .RST(RST), .CFG_DONE(CFG_DONE), .DONE_IN(DONE_IN),
      .DONE_OUT(b_do), .GOE(b_goe), .GWDIS(b_gw), .GSR(b_gsr),
      .PHASE(b_ph), .WAKEUP_DONE(b_wk)
   );

   startup_seq_gen #(.SYNC_DONE(1), .DONE_PHASE(2)) dut_c (
      .UCLK(UCLK), .RST(RST), .CFG_DONE(CFG_DONE), .DONE_IN(DONE_IN),
      .DONE_OUT(c_do), .GOE(c_goe), .GWDIS(c_gw), .GSR(c_gsr),
      .PHASE(c_ph), .WAKEUP_DONE(c_wk)
   );

   startup_seq_gen #(.DONE_PHASE(4), .GOE_PHASE(4), .GWD_PHASE(4), .GSR_PHASE(4)) dut_d (
      .UCLK(UCLK), .RST(RST), .CFG_DONE(CFG_DONE), .DONE_IN(DONE_IN),
      .DONE_OUT(d_do), .GOE(d_goe), .GWDIS(d_gw), .GSR(d_gsr),
      .PHASE(d_ph), .WAKEUP_DONE(d_wk)
   );

   initial UCLK = 1'b0;
   always #5 UCLK = ~UCLK;

   task automatic tick;
      @(posedge UCLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_dut(input string tag,
                          input logic [2:0] ph, input logic d, input logic g,
                          input logic w, input logic s, input logic wk,
                          input logic [2:0] eph, input logic ed, input logic eg,
                          input logic ew, input logic es, input logic ewk);
      chk({tag, "_phase"}, 8'(ph), 8'(eph));
      chk({tag, "_done"},  8'(d),  8'(ed));
      chk({tag, "_goe"},   8'(g),  8'(eg));
      chk({tag, "_gwdis"}, 8'(w),  8'(ew));
      chk({tag, "_gsr"},   8'(s),  8'(es));
      chk({tag, "_wkdone"}, 8'(wk), 8'(ewk));
   endtask

   initial begin
      RST      = 1'b1;
      CFG_DONE = 1'b0;
      DONE_IN  = 1'b0;

      tick;
      chk_dut("a_rst", a_ph, a_do, a_goe, a_gw, a_gsr, a_wk, 3'd0, 0, 0, 1, 1, 0);
      chk_dut("c_rst", c_ph, c_do, c_goe, c_gw, c_gsr, c_wk, 3'd0, 0, 0, 1, 1, 0);
      RST = 1'b0;

      repeat (9) tick;
      chk_dut("a_e9", a_ph, a_do, a_goe, a_gw, a_gsr, a_wk, 3'd0, 0, 0, 1, 1, 0);
      chk_dut("d_e9", d_ph, d_do, d_goe, d_gw, d_gsr, d_wk, 3'd0, 0, 0, 1, 1, 0);
      CFG_DONE = 1'b1;

      tick;
      tick;
      chk("a_e11_phase", 8'(a_ph), 8'd0);

      tick; // edge 12
      chk_dut("a_e12", a_ph, a_do, a_goe, a_gw, a_gsr, a_wk, 3'd1, 1, 0, 1, 1, 0);
      chk("b_e12_phase", 8'(b_ph), 8'd1);
      chk("b_e12_done", 8'(b_do), 8'd1);
      chk("c_e12_phase", 8'(c_ph), 8'd1);
      chk("c_e12_done", 8'(c_do), 8'd0);
      chk_dut("d_e12", d_ph, d_do, d_goe, d_gw, d_gsr, d_wk, 3'd1, 0, 0, 1, 1, 0);
      CFG_DONE = 1'b0;

      tick; // edge 13
      chk_dut("a_e13", a_ph, a_do, a_goe, a_gw, a_gsr, a_wk, 3'd2, 1, 1, 1, 1, 0);
      chk_dut("c_e13", c_ph, c_do, c_goe, c_gw, c_gsr, c_wk, 3'd2, 1, 1, 1, 1, 0);
      chk("b_e13_phase", 8'(b_ph), 8'd1);
      chk("b_e13_goe", 8'(b_goe), 8'd0);
      chk_dut("d_e13", d_ph, d_do, d_goe, d_gw, d_gsr, d_wk, 3'd2, 0, 0, 1, 1, 0);
      CFG_DONE = 1'b1;

      tick; // edge 14
      chk_dut("a_e14", a_ph, a_do, a_goe, a_gw, a_gsr, a_wk, 3'd3, 1, 1, 0, 0, 0);
      chk_dut("d_e14", d_ph, d_do, d_goe, d_gw, d_gsr, d_wk, 3'd3, 0, 0, 1, 1, 0);
      chk("b_e14_goe", 8'(b_goe), 8'd0);

      tick; // edge 15
      chk_dut("a_e15", a_ph, a_do, a_goe, a_gw, a_gsr, a_wk, 3'd4, 1, 1, 0, 0, 0);
      chk_dut("d_e15", d_ph, d_do, d_goe, d_gw, d_gsr, d_wk, 3'd4, 1, 1, 0, 0, 0);
      chk("b_e15_phase", 8'(b_ph), 8'd2);
      chk("b_e15_goe", 8'(b_goe), 8'd1);

      tick; // edge 16
      chk_dut("a_e16", a_ph, a_do, a_goe, a_gw, a_gsr, a_wk, 3'd5, 1, 1, 0, 0, 1);
      chk_dut("d_e16", d_ph, d_do, d_goe, d_gw, d_gsr, d_wk, 3'd5, 1, 1, 0, 0, 1);

      for (int e = 17; e <= 63; e++) begin
         tick;
         chk($sformatf("c_stall_e%0d_phase", e), 8'(c_ph), 8'd2);
         chk($sformatf("c_stall_e%0d_gsr", e), 8'(c_gsr), 8'd1);
         if (e == 23) chk("b_e23_phase", 8'(b_ph), 8'd4);
         if (e == 24) chk_dut("b_e24", b_ph, b_do, b_goe, b_gw, b_gsr, b_wk, 3'd5, 1, 1, 0, 0, 1);
      end
      DONE_IN = 1'b1;

      tick;
      tick; // edge 65
      chk("c_e65_phase", 8'(c_ph), 8'd2);
      tick; // edge 66
      chk_dut("c_e66", c_ph, c_do, c_goe, c_gw, c_gsr, c_wk, 3'd3, 1, 1, 0, 0, 0);
      DONE_IN = 1'b0;
      tick;
      tick; // edge 68
      chk_dut("c_e68", c_ph, c_do, c_goe, c_gw, c_gsr, c_wk, 3'd5, 1, 1, 0, 0, 1);

      #2 RST = 1'b1;
      #1;
      chk_dut("a_arst1", a_ph, a_do, a_goe, a_gw, a_gsr, a_wk, 3'd0, 0, 0, 1, 1, 0);
      chk_dut("b_arst1", b_ph, b_do, b_goe, b_gw, b_gsr, b_wk, 3'd0, 0, 0, 1, 1, 0);
      chk_dut("d_arst1", d_ph, d_do, d_goe, d_gw, d_gsr, d_wk, 3'd0, 0, 0, 1, 1, 0);
      #1 RST = 1'b0;

      tick;
      tick;
      chk("a_r1e2_phase", 8'(a_ph), 8'd0);
      tick;
      chk("a_r1e3_phase", 8'(a_ph), 8'd1);
      chk("a_r1e3_done", 8'(a_do), 8'd1);
      tick;
      tick;
      chk("a_r1e5_phase", 8'(a_ph), 8'd3);
      chk("c_r1e5_phase", 8'(c_ph), 8'd2);

      #2 RST = 1'b1;
      #1;
      chk_dut("a_arst2", a_ph, a_do, a_goe, a_gw, a_gsr, a_wk, 3'd0, 0, 0, 1, 1, 0);
      chk_dut("c_arst2", c_ph, c_do, c_goe, c_gw, c_gsr, c_wk, 3'd0, 0, 0, 1, 1, 0);
      #1 RST = 1'b0;

      tick;
      tick;
      chk("a_r2e2_phase", 8'(a_ph), 8'd0);
      tick;
      chk_dut("a_r2e3", a_ph, a_do, a_goe, a_gw, a_gsr, a_wk, 3'd1, 1, 0, 1, 1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
